calc_alu_seq: RTL and testbench
===============================

// Module: calc_alu_seq
// PURPOSE
//  Arithmetic back end of the calculator; reads the operand/operator registers written by memory
//  (save1, save2, op_out) and computes the result fed back to memory's res input.
//  Sequential: add/sub single-cycle; mul shift-add and div restoring, each WIDTH iterations.
//  Started by the same equ_enable pulse memory sees; cleared by the same clear_enable.
// PARAMETERS
//  WIDTH  16  operand/result width in bits; also the iteration count for mul/div
// PORTS
//  clk       in   1      system clock, rising edge
//  rst       in   1      asynchronous reset, active-high
//  clear     in   1      synchronous clear (from clear_enable)
//  start     in   1      compute request (from equ_enable), sampled only in IDLE
//  a_in      in   WIDTH  operand A, unsigned binary (from save1)
//  b_in      in   WIDTH  operand B, unsigned binary (from save2)
//  op_in     in   4      [1:0] 00 add, 01 sub, 10 mul, 11 div; [2] see CONFIGURATION; [3] ignored
//  res       out  WIDTH  result, held until next done or clear
//  busy      out  1      high while in CALC
//  done      out  1      one-cycle pulse when res/err update
//  err       out  1      overflow / negative / divide-by-zero flag, valid with done, held
// BEHAVIOUR
//  Reset (async) and clear (sync): res=0, err=0, busy=0, done=0, state=IDLE, iteration count=0.
//  States: IDLE -> CALC -> IDLE. done is registered, asserted on the edge CALC exits.
//  IDLE: on edge with start=1: latch a_in, b_in, op_in into internal regs; busy<=1; state<=CALC.
//   Inputs changing after that edge do not affect the running operation.
//  CALC add: next edge res<=A+B mod 2^WIDTH, err<=carry out; done<=1, busy<=0, IDLE.
//  CALC sub: next edge res<=A-B mod 2^WIDTH, err<=(A<B); done, IDLE.
//  CALC mul: WIDTH shift-add iterations, one per edge; on last: res<=low WIDTH bits of product,
//   err<=(product >= 2^WIDTH); done, IDLE. done on edge WIDTH after start edge.
//  CALC div: b=0 -> next edge res<=all ones, err<=1, done, IDLE (no iterations).
//   Else WIDTH restoring iterations; on last: res<=quotient, err<=0; done, IDLE.
//  Latency (edges after start edge): add/sub/div-by-0 = 1, mul/div = WIDTH.
//  start while busy: ignored, no queuing. start coincident with done edge: ignored (still CALC).
//  clear has priority over start and over completion in the same cycle; aborts CALC, no done.
//  rst mid-operation: immediate abort, outputs to reset values, no done.
//  done never high two consecutive cycles; busy and done never high together.
//  op_in[3] has no effect in any build.
// CONFIGURATION
//  CALC_ALU_MOD_EN defined: for div, op_in[2]=1 returns remainder instead of quotient in res
//   (same latency; b=0 still res=all ones, err=1). op_in[2] ignored for add/sub/mul.
//  CALC_ALU_MOD_EN undefined: op_in[2] ignored everywhere; remainder logic not built.
// TESTING (WIDTH=16)
//  rst high mid-mul then low -> res=0, err=0, busy=0, no done; next start works normally.
//  add a=0xFFFF b=0x0001 -> 1 edge later done, res=0x0000, err=1; a=0x1234 b=0x0001 -> 0x1235, err=0.
//  sub a=5 b=9 -> res=0xFFFC, err=1; mul 300*200 -> 16 edges, res=60000, err=0;
//   mul 300*300 -> res=0x5F90, err=1.
//  div 1000/7 -> 16 edges, res=142, err=0; div 5/0 -> 1 edge, res=0xFFFF, err=1;
//   with CALC_ALU_MOD_EN, op_in=4'b0111 1000/7 -> res=6.
//  start pulsed again at edge 5 of a mul, operands changed -> ignored; res from original operands.
//  clear and start same edge in IDLE -> stays IDLE, busy=0; clear at edge 8 of div -> abort, no done.

Source files
------------

// File: rtl/calc_alu_seq.sv
// calc_alu_seq: sequential arithmetic back end of the calculator.
// Takes the operands and operator held in memory (save1, save2, op_out).
// Computes a result that is fed back to memory's res input.
// add and sub finish in one cycle.
// mul is a WIDTH-step shift-add; div is a WIDTH-step restoring divide.
// Optional build macro CALC_ALU_MOD_EN: when defined, a div with op_in[2]=1 returns the
// remainder in place of the quotient. When it is undefined, the remainder select is not built.
module calc_alu_seq #(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clear,
  input  logic             start,
  input  logic [WIDTH-1:0] a_in,
  input  logic [WIDTH-1:0] b_in,
  input  logic [3:0]       op_in,
  output logic [WIDTH-1:0] res,
  output logic             busy,
  output logic             done,
  output logic             err
);

  localparam int CNT_W = $clog2(WIDTH + 1);

  typedef enum logic {
    IDLE = 1'b0,
    CALC = 1'b1
  } state_t;

  state_t           state, state_nxt;
  logic [CNT_W-1:0] cnt, cnt_nxt;

  // Operands and operator captured at the start edge.
  logic [WIDTH-1:0] a_r, b_r;
  logic [1:0]       op_r;
`ifdef CALC_ALU_MOD_EN
  logic             mod_r;
`endif

  // Shared iteration registers.
  // mul: hi_r holds the running upper half; lo_r holds the multiplier, which shifts out
  //      while product bits shift in.
  // div: hi_r holds the partial remainder; lo_r holds the dividend, which shifts out
  //      while quotient bits shift in.
  logic [WIDTH-1:0] hi_r, lo_r;

  logic [2*WIDTH-1:0] mul_nxt, div_nxt;
  logic [WIDTH:0]     add_full;
  logic               last_iter;
  logic               fin;
  logic [WIDTH-1:0]   res_nxt;
  logic               err_nxt;
  logic               accept;

`ifndef CALC_ALU_MOD_EN
  logic unused_op;
  assign unused_op = ^{op_in[3], op_in[2]};
`else
  logic unused_op;
  assign unused_op = op_in[3];
`endif

  // One shift-add step.
  // Conditionally add A to the upper half, then shift {carry, hi, lo} right by one bit.
  function automatic logic [2*WIDTH-1:0] mul_step(input logic [WIDTH-1:0] hi,
                                                  input logic [WIDTH-1:0] lo,
                                                  input logic [WIDTH-1:0] a);
    logic [WIDTH:0] sum;
    sum = {1'b0, hi} + (lo[0] ? {1'b0, a} : {(WIDTH+1){1'b0}});
    return {sum[WIDTH:1], sum[0], lo[WIDTH-1:1]};
  endfunction

  // One restoring-divide step.
  // Shift the next dividend bit into the remainder and trial-subtract B.
  // The remainder is always below B, so the shifted value is below 2B.
  // Therefore bit WIDTH of the difference is a clean borrow flag.
  function automatic logic [2*WIDTH-1:0] div_step(input logic [WIDTH-1:0] hi,
                                                  input logic [WIDTH-1:0] lo,
                                                  input logic [WIDTH-1:0] b);
    logic [WIDTH:0] sh;
    logic [WIDTH:0] diff;
    sh   = {hi, lo[WIDTH-1]};
    diff = sh - {1'b0, b};
    if (diff[WIDTH]) begin
      return {sh[WIDTH-1:0], lo[WIDTH-2:0], 1'b0};
    end
    return {diff[WIDTH-1:0], lo[WIDTH-2:0], 1'b1};
  endfunction

  assign accept    = (state == IDLE) && start && !clear;
  assign mul_nxt   = mul_step(hi_r, lo_r, a_r);
  assign div_nxt   = div_step(hi_r, lo_r, b_r);
  assign add_full  = {1'b0, a_r} + {1'b0, b_r};
  assign last_iter = (cnt == CNT_W'(WIDTH - 1));

  // Next-state, iteration count and completion result.
  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    fin       = 1'b0;
    res_nxt   = res;
    err_nxt   = err;
    if (clear) begin
      state_nxt = IDLE;
      cnt_nxt   = '0;
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            state_nxt = CALC;
            cnt_nxt   = '0;
          end
        end
        CALC: begin
          case (op_r)
            2'b00: begin
              fin     = 1'b1;
              res_nxt = add_full[WIDTH-1:0];
              err_nxt = add_full[WIDTH];
            end
            2'b01: begin
              fin     = 1'b1;
              res_nxt = a_r - b_r;
              err_nxt = (a_r < b_r);
            end
            2'b10: begin
              cnt_nxt = cnt + 1'b1;
              if (last_iter) begin
                fin     = 1'b1;
                res_nxt = mul_nxt[WIDTH-1:0];
                err_nxt = |mul_nxt[2*WIDTH-1:WIDTH];
              end
            end
            default: begin
              if (b_r == '0) begin
                fin     = 1'b1;
                res_nxt = '1;
                err_nxt = 1'b1;
              end else begin
                cnt_nxt = cnt + 1'b1;
                if (last_iter) begin
                  fin     = 1'b1;
                  err_nxt = 1'b0;
`ifdef CALC_ALU_MOD_EN
                  res_nxt = mod_r ? div_nxt[2*WIDTH-1:WIDTH] : div_nxt[WIDTH-1:0];
`else
                  res_nxt = div_nxt[WIDTH-1:0];
`endif
                end
              end
            end
          endcase
          if (fin) begin
            state_nxt = IDLE;
            cnt_nxt   = '0;
          end
        end
        default: begin
          state_nxt = IDLE;
          cnt_nxt   = '0;
        end
      endcase
    end
  end

  // Control and visible outputs: async reset, then the sync clear path via the next-state logic.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
      cnt   <= '0;
      busy  <= 1'b0;
      done  <= 1'b0;
      res   <= '0;
      err   <= 1'b0;
    end else if (clear) begin
      state <= IDLE;
      cnt   <= '0;
      busy  <= 1'b0;
      done  <= 1'b0;
      res   <= '0;
      err   <= 1'b0;
    end else begin
      state <= state_nxt;
      cnt   <= cnt_nxt;
      busy  <= (state_nxt == CALC);
      done  <= fin;
      if (fin) begin
        res <= res_nxt;
        err <= err_nxt;
      end
    end
  end

  // Datapath: capture operands on acceptance, then advance the mul/div working registers.
  always_ff @(posedge clk) begin
    if (accept) begin
      a_r  <= a_in;
      b_r  <= b_in;
      op_r <= op_in[1:0];
`ifdef CALC_ALU_MOD_EN
      mod_r <= op_in[2];
`endif
      hi_r <= '0;
      lo_r <= (op_in[1:0] == 2'b10) ? b_in : a_in;
    end else if (state == CALC) begin
      if (op_r == 2'b10) begin
        {hi_r, lo_r} <= mul_nxt;
      end else if (op_r == 2'b11) begin
        {hi_r, lo_r} <= div_nxt;
      end
    end
  end

endmodule

// File: tb/tb_calc_alu_seq.sv
// Scoreboard bench for calc_alu_seq.
// Directed cases come first, then randomized operations.
// Expected results come from plain integer arithmetic.
module tb_calc_alu_seq;
  localparam int W = 16;

  logic         clk = 1'b0;
  logic         rst, clear, start;
  logic [W-1:0] a_in, b_in;
  logic [3:0]   op_in;
  logic [W-1:0] res;
  logic         busy, done, err;

  calc_alu_seq #(.WIDTH(W)) dut (
    .clk(clk), .rst(rst), .clear(clear), .start(start),
    .a_in(a_in), .b_in(b_in), .op_in(op_in),
    .res(res), .busy(busy), .done(done), .err(err)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [W-1:0] res;
    logic         err;
    int           lat;
    int           t0;
  } exp_t;

  exp_t sb[$];
  int   total = 0;
  int   bad   = 0;
  int   cyc   = 0;
  logic prev_done = 1'b0;
  exp_t mon_e;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", nm, act, req);
    end
  endtask

  function automatic exp_t model(input logic [3:0] op, input logic [W-1:0] a,
                                 input logic [W-1:0] b);
    exp_t e;
    longint unsigned x;
    e.t0 = 0;
    case (op[1:0])
      2'b00: begin
        x = longint'(a) + longint'(b);
        e.res = W'(x % 65536);
        e.err = (x > 65535);
        e.lat = 1;
      end
      2'b01: begin
        x = (longint'(a) + 65536 - longint'(b)) % 65536;
        e.res = W'(x);
        e.err = (a < b);
        e.lat = 1;
      end
      2'b10: begin
        x = longint'(a) * longint'(b);
        e.res = W'(x % 65536);
        e.err = (x > 65535);
        e.lat = W;
      end
      default: begin
        if (b == 0) begin
          e.res = 16'hFFFF;
          e.err = 1'b1;
          e.lat = 1;
        end else begin
`ifdef CALC_ALU_MOD_EN
          e.res = op[2] ? (a % b) : (a / b);
`else
          e.res = a / b;
`endif
          e.err = 1'b0;
          e.lat = W;
        end
      end
    endcase
    return e;
  endfunction

  // Monitor: pops the scoreboard on every done pulse and checks the result and latency.
  always @(negedge clk) begin
    if (!rst && done) begin
      if (sb.size() == 0) begin
        total++;
        bad++;
        $display("FAIL unexpected_done: got done with res %0h want no done", res);
      end else begin
        mon_e = sb.pop_front();
        chk("res", {16'h0, res}, {16'h0, mon_e.res});
        chk("err", {31'h0, err}, {31'h0, mon_e.err});
        chk("latency", cyc - mon_e.t0 - 1, mon_e.lat);
      end
      chk("busy_with_done", {31'h0, busy}, 32'h0);
      chk("done_twice", {31'h0, prev_done}, 32'h0);
    end
    prev_done = done;
  end

  // Called at a negedge; waits for idle, then drives a one-cycle start (or two cycles if hold).
  task automatic issue(input logic [3:0] op, input logic [W-1:0] a, input logic [W-1:0] b,
                       input bit hold = 1'b0);
    exp_t e;
    int   n = 0;
    while (busy && n < 100) begin
      @(negedge clk);
      n++;
    end
    if (busy) begin
      total++;
      bad++;
      $display("FAIL idle_timeout: busy got 1 want 0");
    end
    e = model(op, a, b);
    e.t0 = cyc;
    sb.push_back(e);
    op_in = op;
    a_in  = a;
    b_in  = b;
    start = 1'b1;
    @(negedge clk);
    if (hold) @(negedge clk);
    start = 1'b0;
    a_in  = W'($urandom);
    b_in  = W'($urandom);
    op_in = 4'($urandom);
  endtask

  task automatic drain();
    int n = 0;
    while ((sb.size() != 0 || busy) && n < 200) begin
      @(negedge clk);
      n++;
    end
    if (sb.size() != 0) begin
      total++;
      bad++;
      $display("FAIL drain_timeout: got %0d pending want 0", sb.size());
      sb.delete();
    end
  endtask

  initial begin
    #500000;
    $display("FAIL global_timeout: got no finish want finish");
    $fatal(1, "timeout");
  end

  initial begin
    logic [3:0]   op;
    logic [W-1:0] a, b;
    rst = 1'b1; clear = 1'b0; start = 1'b0;
    a_in = '0; b_in = '0; op_in = '0;
    repeat (2) @(negedge clk);
    chk("rst_res", {16'h0, res}, 32'h0);
    chk("rst_err", {31'h0, err}, 32'h0);
    chk("rst_busy", {31'h0, busy}, 32'h0);
    chk("rst_done", {31'h0, done}, 32'h0);
    rst = 1'b0;
    @(negedge clk);

    // Directed cases
    issue(4'b0000, 16'hFFFF, 16'h0001);
    issue(4'b0000, 16'h1234, 16'h0001);
    issue(4'b0001, 16'd5, 16'd9);
    issue(4'b0010, 16'd300, 16'd200);
    issue(4'b0010, 16'd300, 16'd300);
    issue(4'b0011, 16'd1000, 16'd7);
    issue(4'b0011, 16'd5, 16'd0);
    issue(4'b1011, 16'd65535, 16'd1);
    issue(4'b1001, 16'd9, 16'd5);
`ifdef CALC_ALU_MOD_EN
    issue(4'b0111, 16'd1000, 16'd7);
`else
    issue(4'b0111, 16'd1000, 16'd7);
`endif
    drain();

    // A second start at edge 5 of a mul, with changed operands, is ignored.
    issue(4'b0010, 16'd123, 16'd45);
    repeat (4) @(negedge clk);
    op_in = 4'b0000; a_in = 16'd1; b_in = 16'd2; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    drain();

    // A start held across the done edge of an add is ignored.
    issue(4'b0000, 16'd40, 16'd2, 1'b1);
    repeat (3) @(negedge clk);
    drain();

    // clear and start on the same edge while in IDLE.
    op_in = 4'b0000; a_in = 16'd7; b_in = 16'd8; start = 1'b1; clear = 1'b1;
    @(negedge clk);
    start = 1'b0; clear = 1'b0;
    chk("clr_start_busy", {31'h0, busy}, 32'h0);
    chk("clr_start_res", {16'h0, res}, 32'h0);
    repeat (3) @(negedge clk);

    // clear at edge 8 of a div aborts it with no done.
    issue(4'b0000, 16'd100, 16'd200);
    drain();
    issue(4'b0011, 16'd1000, 16'd7);
    void'(sb.pop_back());
    repeat (7) @(negedge clk);
    clear = 1'b1;
    @(negedge clk);
    clear = 1'b0;
    chk("clr_div_res", {16'h0, res}, 32'h0);
    chk("clr_div_err", {31'h0, err}, 32'h0);
    chk("clr_div_busy", {31'h0, busy}, 32'h0);
    repeat (20) @(negedge clk);

    // rst in the middle of a mul.
    issue(4'b0000, 16'hFFFF, 16'h0002);
    drain();
    issue(4'b0010, 16'd300, 16'd300);
    void'(sb.pop_back());
    repeat (3) @(negedge clk);
    rst = 1'b1;
    #1;
    chk("rst_mid_res", {16'h0, res}, 32'h0);
    chk("rst_mid_err", {31'h0, err}, 32'h0);
    chk("rst_mid_busy", {31'h0, busy}, 32'h0);
    chk("rst_mid_done", {31'h0, done}, 32'h0);
    @(negedge clk);
    rst = 1'b0;
    repeat (20) @(negedge clk);
    issue(4'b0010, 16'd300, 16'd200);
    drain();

    // Randomized operations
    for (int i = 0; i < 60; i++) begin
      op = 4'($urandom);
      a  = W'($urandom);
      b  = ($urandom_range(0, 6) == 0) ? 16'd0 : W'($urandom);
      if (op[1:0] == 2'b10 && $urandom_range(0, 1) == 1) begin
        a = W'($urandom_range(0, 255));
        b = W'($urandom_range(0, 255));
      end
      if (op[1:0] == 2'b11 && $urandom_range(0, 2) == 0) b = W'($urandom_range(1, 20));
      issue(op, a, b);
      if ($urandom_range(0, 3) == 0) repeat ($urandom_range(1, 3)) @(negedge clk);
    end
    drain();
    repeat (3) @(negedge clk);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
